// File: rtl/obj_pkg.sv
// obj_pkg: shared screen/sprite constants and blitter state encoding
package obj_pkg;
    localparam int OBJ_SIZE = 32;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    typedef enum logic [2:0] {IDLE, FETCH, EMIT, WRITE, DONE} blit_state_t;
endpackage

// File: rtl/obj_clip.sv
// obj_clip: local-to-global pixel mapping with an on-screen test (11-bit sums, no wrap)
module obj_clip #(
    parameter int SCREEN_W = obj_pkg::SCREEN_W,
    parameter int SCREEN_H = obj_pkg::SCREEN_H
) (
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [4:0] lx,
    input  logic [4:0] ly,
    output logic [9:0] gx,
    output logic [9:0] gy,
    output logic       on_screen
);
    logic [10:0] sx, sy;
    assign sx = {1'b0, pos_x} + {6'b0, lx};
    assign sy = {1'b0, pos_y} + {6'b0, ly};
    assign gx = sx[9:0];
    assign gy = sy[9:0];
    assign on_screen = (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));
endmodule

// File: rtl/obj_blitter.sv
// obj_blitter: raster-walks a 32x32 sprite and issues clipped framebuffer writes; optional colour key via TRANSPARENCY_EN
module obj_blitter #(
    parameter int OBJ_SIZE          = obj_pkg::OBJ_SIZE,
    parameter int SCREEN_W          = obj_pkg::SCREEN_W,
    parameter int SCREEN_H          = obj_pkg::SCREEN_H,
    parameter int COLOR_W           = 3,
    parameter int TRANSPARENT_COLOR = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         obj_x_pos,
    input  logic [9:0]         obj_y_pos,
    output logic               busy,
    output logic               done,
    output logic [4:0]         sprite_x,
    output logic [4:0]         sprite_y,
    input  logic [COLOR_W-1:0] sprite_data,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [9:0]         wr_x,
    output logic [9:0]         wr_y,
    output logic [COLOR_W-1:0] wr_color
);
    import obj_pkg::*;
    localparam logic [4:0] LAST = 5'(OBJ_SIZE - 1);
    blit_state_t state, state_n;
    logic [9:0] px, py, gx, gy;
    logic [4:0] lx, ly;
    logic on_screen, visible, last, adv;

    obj_clip #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clip (
        .pos_x(px), .pos_y(py), .lx(lx), .ly(ly),
        .gx(gx), .gy(gy), .on_screen(on_screen)
    );

`ifdef TRANSPARENCY_EN
    assign visible = on_screen && (sprite_data != COLOR_W'(TRANSPARENT_COLOR));
`else
    assign visible = on_screen;
`endif
    assign last     = (lx == LAST) && (ly == LAST);
    assign adv      = (state == EMIT && !visible) || (state == WRITE && wr_ready);
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign wr_valid = state == WRITE;
    assign sprite_x = lx;
    assign sprite_y = ly;

    // next-state: one fetch/emit pair per pixel, a write stall only for visible pixels
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FETCH : IDLE;
            FETCH:   state_n = EMIT;
            EMIT:    state_n = visible ? WRITE : (last ? DONE : FETCH);
            WRITE:   state_n = wr_ready ? (last ? DONE : FETCH) : WRITE;
            default: state_n = IDLE;
        endcase
    end

    // state, latched position, raster counters and the registered write payload
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            px       <= '0;
            py       <= '0;
            lx       <= '0;
            ly       <= '0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_color <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                px <= obj_x_pos;
                py <= obj_y_pos;
                lx <= '0;
                ly <= '0;
            end
            if (adv) begin
                lx <= (lx == LAST) ? 5'd0 : lx + 5'd1;
                if (lx == LAST) ly <= (ly == LAST) ? 5'd0 : ly + 5'd1;
            end
            if (state == EMIT && visible) begin
                wr_x     <= gx;
                wr_y     <= gy;
                wr_color <= sprite_data;
            end
        end
    end
endmodule

// File: tb/tb_obj_blitter.sv
// tb_obj_blitter: table-driven checks of obj_blitter write stream, clipping, handshake and reset
module tb_obj_blitter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] obj_x_pos = '0, obj_y_pos = '0;
    logic       busy, done, wr_valid;
    logic       wr_ready = 1'b1;
    logic [4:0] sprite_x, sprite_y;
    logic [2:0] sprite_data = '0;
    logic [9:0] wr_x, wr_y;
    logic [2:0] wr_color;
    int rom_mode = 0;
    int checks = 0;
    int failures = 0;

`ifdef TRANSPARENCY_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    obj_blitter dut (
        .clk(clk), .reset(reset), .start(start),
        .obj_x_pos(obj_x_pos), .obj_y_pos(obj_y_pos),
        .busy(busy), .done(done),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_data(sprite_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] rom_color(input int mode, input int x, input int y);
        if (mode == 1 && x < 16) return 3'd0;
        return 3'(((x + y) % 7) + 1);
    endfunction

    always @(posedge clk) sprite_data <= rom_color(rom_mode, int'(sprite_x), int'(sprite_y));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int px, py, mode, rnd, extra;
        int n_wr, fx, fy, lx, ly, done_n;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic [22:0] exp_q[$];
        logic [22:0] held, pay;
        logic stall;
        int nw, done_seen, done_cnt, fx, fy, lxw, lyw;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                int gx, gy;
                logic [2:0] c;
                gx = v.px + x;
                gy = v.py + y;
                c = rom_color(v.mode, x, y);
                if (gx < 640 && gy < 480 && !(TEN && c == 3'd0))
                    exp_q.push_back({10'(gx), 10'(gy), c});
            end
        nw = 0; done_seen = 0; done_cnt = 0; stall = 0; held = '0;
        fx = -1; fy = -1; lxw = -1; lyw = -1;
        rom_mode = v.mode;
        obj_x_pos = 10'(v.px);
        obj_y_pos = 10'(v.py);
        wr_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int n = 1; n < 20000; n++) begin
            start = (n == v.extra);
            obj_x_pos = (n == v.extra) ? 10'd400 : 10'(v.px);
            obj_y_pos = (n == v.extra) ? 10'd400 : 10'(v.py);
            wr_ready = v.rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            pay = {wr_x, wr_y, wr_color};
            if (stall) begin
                chk("hold_valid", 32'(wr_valid), 32'd1);
                chk("hold_payload", 32'(pay), 32'(held));
            end
            if (done_seen != 0 && n == done_seen + 1) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("done_one_cycle", 32'(done), 32'd0);
                break;
            end
            if (done) begin
                done_cnt++;
                if (done_seen == 0) done_seen = n;
            end
            if (wr_valid && wr_ready) begin
                if (nw < exp_q.size()) chk("write_seq", 32'(pay), 32'(exp_q[nw]));
                if (nw == 0) begin fx = int'(wr_x); fy = int'(wr_y); end
                lxw = int'(wr_x);
                lyw = int'(wr_y);
                nw++;
            end
            stall = wr_valid && !wr_ready;
            held = pay;
            @(negedge clk);
        end
        start = 1'b0;
        wr_ready = 1'b1;
        if (done_seen == 0) chk("done_timeout", 32'd0, 32'd1);
        chk("write_count", 32'(nw), 32'(v.n_wr));
        chk("first_write", {16'(fx), 16'(fy)}, {16'(v.fx), 16'(v.fy)});
        chk("last_write", {16'(lxw), 16'(lyw)}, {16'(v.lx), 16'(v.ly)});
        chk("done_pulses", 32'(done_cnt), 32'd1);
        if (v.done_n != 0) chk("done_cycle", 32'(done_seen), 32'(v.done_n));
    endtask

    vec_t vecs[6];

    initial begin
        int hs;
        vecs[0] = '{px:100, py:50,  mode:0, rnd:0, extra:0,   n_wr:1024, fx:100, fy:50,  lx:131, ly:81,  done_n:3073};
        vecs[1] = '{px:620, py:470, mode:0, rnd:0, extra:0,   n_wr:200,  fx:620, fy:470, lx:639, ly:479, done_n:2249};
        vecs[2] = '{px:300, py:200, mode:1, rnd:0, extra:0,   n_wr:TEN ? 512 : 1024, fx:TEN ? 316 : 300, fy:200,
                    lx:331, ly:231, done_n:TEN ? 2561 : 3073};
        vecs[3] = '{px:10,  py:20,  mode:0, rnd:1, extra:0,   n_wr:1024, fx:10,  fy:20,  lx:41,  ly:51,  done_n:0};
        vecs[4] = '{px:5,   py:5,   mode:0, rnd:0, extra:500, n_wr:1024, fx:5,   fy:5,   lx:36,  ly:36,  done_n:3073};
        vecs[5] = '{px:639, py:479, mode:0, rnd:0, extra:0,   n_wr:1,    fx:639, fy:479, lx:639, ly:479, done_n:2050};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_payload", {wr_x, wr_y, wr_color}, 32'd0);
        chk("rst_sprite_addr", {sprite_x, sprite_y}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        rom_mode = 0;
        obj_x_pos = 10'd200;
        obj_y_pos = 10'd100;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        for (int n = 0; n < 5000; n++) begin
            if (wr_valid && hs == 300) break;
            if (wr_valid) hs++;
            @(negedge clk);
        end
        chk("rst_reached_px300", 32'(hs), 32'd300);
        chk("rst_in_write", 32'(wr_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_wr_valid", 32'(wr_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sprite_addr", {sprite_x, sprite_y}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_vec('{px:0, py:0, mode:0, rnd:0, extra:0, n_wr:1024, fx:0, fy:0, lx:31, ly:31, done_n:3073});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/obj_blitter.md
# obj_blitter

Sprite blitter: walks every local pixel of a 32×32 object, fetches its colour from the sprite ROM, and issues framebuffer writes at the matching global screen coordinate (global = object position + local offset). It is the write-side counterpart of the global-to-local pixel mapping used on the display path. It sits between the game logic, which supplies the object position and start, and the framebuffer write port.

## Interface
Parameters:
- OBJ_SIZE, 32: sprite edge length in pixels; local counters are log2(OBJ_SIZE) = 5 bits.
- SCREEN_W, 640: visible width; writes at x ≥ SCREEN_W are clipped.
- SCREEN_H, 480: visible height; writes at y ≥ SCREEN_H are clipped.
- COLOR_W, 3: colour width.
- TRANSPARENT_COLOR, 0: colour key; used only under TRANSPARENCY_EN.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to blit; ignored while busy.
- obj_x_pos  in  10  object left edge in global pixels; latched on accepted start.
- obj_y_pos  in  10  object top edge in global pixels; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel.
- sprite_x  out  5  sprite ROM local column address.
- sprite_y  out  5  sprite ROM local row address.
- sprite_data  in  COLOR_W  ROM read data, valid one cycle after the address.
- wr_valid  out  1  framebuffer write request.
- wr_ready  in  1  framebuffer accepts when wr_valid && wr_ready.
- wr_x  out  10  global write column.
- wr_y  out  10  global write row.
- wr_color  out  COLOR_W  write colour.

## Operation
- States: IDLE, FETCH, EMIT, WRITE, DONE.
- IDLE: start=1 latches the positions and clears the local counters lx and ly, then goes to FETCH.
- FETCH: sprite_x=lx, sprite_y=ly. Go to EMIT.
- EMIT: sprite_data is valid. Compute gx = obj_x_pos + lx and gy = obj_y_pos + ly in 11 bits, so there is no wrap.
  - Visible if gx < SCREEN_W and gy < SCREEN_H. Under TRANSPARENCY_EN the pixel is also skipped when sprite_data == TRANSPARENT_COLOR.
  - Visible: register wr_x=gx[9:0], wr_y=gy[9:0], wr_color=sprite_data, set wr_valid=1, go to WRITE.
  - Skipped: advance the counters (see below) with no write.
- WRITE: hold wr_valid and the payload stable until wr_ready. On the handshake, clear wr_valid and advance the counters.
- Advance: lx increments; when lx wraps at OBJ_SIZE-1 it returns to 0 and ly increments (raster order, row-major). After (31,31), go to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- start while busy or in DONE is dropped and not queued.
- Reset mid-operation: all state and outputs return to their reset values on that edge, and any in-flight write is abandoned.
- Reset values: busy=0, done=0, wr_valid=0, wr_x=0, wr_y=0, wr_color=0, sprite_x=0, sprite_y=0, state IDLE.

## Timing
- start sampled high at edge T: FETCH during T+1, EMIT during T+2, wr_valid high from T+3.
- Visible pixel with wr_ready held at 1: 3 cycles. Skipped pixel: 2 cycles.
- Fully visible blit with wr_ready held at 1: 3072 cycles from FETCH to the last handshake, then done in the following cycle.
- wr_ready may be low any number of cycles; no combinational path from wr_ready to wr_* outputs.

## Configuration
- TRANSPARENCY_EN defined: pixels whose colour equals TRANSPARENT_COLOR generate no write, and take the 2-cycle skip path.
- TRANSPARENCY_EN undefined: every on-screen pixel is written. The colour-key comparator and the TRANSPARENT_COLOR use are compiled out.

## Structure
- Shared package `obj_pkg`: SCREEN_W, SCREEN_H, OBJ_SIZE constants and the blitter state enum typedef.
- One sub-module `obj_clip` (combinational): inputs are the position and local coordinates; outputs are the global coordinates and an on_screen flag. It is reused by future blitters.

## Test plan
- Position (100,50), wr_ready=1, non-key ROM → 1024 writes, the first at (100,50) and the last at (131,81), in raster order; done pulses exactly 3073 cycles after the start edge.
- Position (620,470) → only the 20×10 = 200 writes with x<640 and y<480 occur; the last write is at (639,479).
- wr_ready toggled pseudo-randomly → payload stable while wr_valid && !wr_ready; no write is lost or duplicated.
- TRANSPARENCY_EN with TRANSPARENT_COLOR=0 and a ROM holding 0 on its left half → 512 writes, all with lx ≥ 16. Without the macro, the same ROM gives 1024 writes.
- reset asserted during WRITE at pixel 300 → wr_valid, busy and done are 0 on the next cycle. A new start at (0,0) then begins again from local (0,0).
- start pulsed again while busy → ignored; exactly one done pulse and 1024 writes.
